// File: rtl/kv_fetch_if.sv
// Fetch-unit bundle: memory read request/response, PC redirect and decode hand-off.
// master = fetch unit; slave = the memory / branch / decode environment around it.
interface kv_fetch_if;
    logic [31:0] o_read_addr;
    logic        o_read_valid;
    logic        i_read_ready;
    logic [31:0] i_read_data;
    logic        i_read_valid;
    logic        o_read_ready;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst_data;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;

    modport master (
        output o_read_addr, o_read_valid, o_read_ready,
        output o_inst_valid, o_inst_data, o_inst_pc,
        input  i_read_ready, i_read_data, i_read_valid,
        input  i_redirect_valid, i_redirect_pc, i_inst_ready
    );

    modport slave (
        input  o_read_addr, o_read_valid, o_read_ready,
        input  o_inst_valid, o_inst_data, o_inst_pc,
        output i_read_ready, i_read_data, i_read_valid,
        output i_redirect_valid, i_redirect_pc, i_inst_ready
    );
endinterface

// File: rtl/kv_fetch.sv
// Credit-limited in-order instruction fetch with PC tagging, redirect flush and stale-response kill.
// Buffered path: response visible one cycle later; KV_FETCH_BYPASS_EN adds same-cycle bypass on empty buffer.
// Backpressure: requests stop when outstanding + buffered reaches DEPTH; responses are always accepted.
module kv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    kv_fetch_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] kill_count;
    logic [CW-1:0] buf_count;
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic [AW-1:0] buf_wr;
    logic [AW-1:0] buf_rd;
    logic [31:0]   pcq_mem     [DEPTH];
    logic [31:0]   buf_pc_mem  [DEPTH];
    logic [31:0]   buf_dat_mem [DEPTH];

    logic          redirect;
    logic [CW:0]   credit_used;
    logic          read_vld;
    logic          req_fire;
    logic          resp_take;
    logic          resp_keep;
    logic          resp_kill;
    logic          buf_empty;
    logic          bypass;
    logic          inst_vld;
    logic          inst_fire;
    logic          buf_push;
    logic          buf_pop;
    logic [31:0]   resp_pc;

    assign redirect    = bus.i_redirect_valid;
    assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
    assign read_vld    = i_rstn & ~redirect & (credit_used < CREDITS);
    assign req_fire    = read_vld & bus.i_read_ready;

    // A response only counts when a request is actually in flight; strays are ignored.
    assign resp_take   = i_rstn & bus.i_read_valid & (outstanding != '0);
    assign resp_keep   = resp_take & ~redirect & (kill_count == '0);
    assign resp_kill   = resp_take & ~redirect & (kill_count != '0);
    assign resp_pc     = pcq_mem[pcq_rd];
    assign buf_empty   = (buf_count == '0);

`ifdef KV_FETCH_BYPASS_EN
    assign bypass      = resp_keep & buf_empty;
`else
    assign bypass      = 1'b0;
`endif

    assign inst_vld    = i_rstn & ~redirect & (~buf_empty | bypass);
    assign inst_fire   = inst_vld & bus.i_inst_ready;
    assign buf_pop     = inst_fire & ~buf_empty;
    assign buf_push    = resp_keep & ~(bypass & bus.i_inst_ready);

    assign bus.o_read_addr  = fetch_pc;
    assign bus.o_read_valid = read_vld;
    assign bus.o_read_ready = i_rstn;
    assign bus.o_inst_valid = inst_vld;
    assign bus.o_inst_data  = !i_rstn ? 32'h0 : (bypass ? bus.i_read_data : buf_dat_mem[buf_rd]);
    assign bus.o_inst_pc    = !i_rstn ? 32'h0 : (bypass ? resp_pc : buf_pc_mem[buf_rd]);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
            outstanding <= '0;
            kill_count  <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= bus.i_redirect_pc & 32'hFFFF_FFFC;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
            // Everything still in flight at a redirect belongs to the abandoned path.
            if (redirect) begin
                kill_count <= outstanding - CW'(resp_take);
            end else if (resp_kill) begin
                kill_count <= kill_count - CW'(1);
            end
            if (req_fire) begin
                pcq_wr <= pcq_wr + AW'(1);
            end
            if (resp_take) begin
                pcq_rd <= pcq_rd + AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn || redirect) begin
            buf_count <= '0;
            buf_wr    <= '0;
            buf_rd    <= '0;
        end else begin
            if (buf_push) begin
                buf_wr <= buf_wr + AW'(1);
            end
            if (buf_pop) begin
                buf_rd <= buf_rd + AW'(1);
            end
            buf_count <= buf_count + CW'(buf_push) - CW'(buf_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr] <= fetch_pc;
        end
        if (buf_push) begin
            buf_pc_mem[buf_wr]  <= resp_pc;
            buf_dat_mem[buf_wr] <= bus.i_read_data;
        end
    end
endmodule

// File: tb/tb_kv_fetch.sv
// Random-stimulus scoreboard bench for kv_fetch: in-order memory model plus epoch-based fetch model.
module tb_kv_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          NCYC     = 2000;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
        int          ep;
    } req_t;

    logic clk;
    logic rstn;
    kv_fetch_if bus();

    kv_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          consumed = 0;
    int          held = 0;
    int          ep = 0;
    logic [31:0] mpc = RESET_PC;
    req_t        pend[$];
    logic [31:0] expq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor / scoreboard: expectations come from the model state at the start of the cycle.
    bit resp;
    bit live;
    bit exp_rv;
    bit exp_iv;
    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_read_valid", {31'b0, bus.o_read_valid}, 32'd0);
            check("rst_read_ready", {31'b0, bus.o_read_ready}, 32'd0);
            check("rst_inst_valid", {31'b0, bus.o_inst_valid}, 32'd0);
            check("rst_inst_data", bus.o_inst_data, 32'd0);
            check("rst_inst_pc", bus.o_inst_pc, 32'd0);
            pend.delete();
            expq.delete();
            held = 0;
            ep++;
            mpc = RESET_PC;
        end else begin
            resp   = bus.i_read_valid && (pend.size() > 0);
            live   = resp && !bus.i_redirect_valid && (pend[0].ep == ep);
            exp_rv = !bus.i_redirect_valid && (pend.size() + held < DEPTH);
`ifdef KV_FETCH_BYPASS_EN
            exp_iv = !bus.i_redirect_valid && (held > 0 || live);
`else
            exp_iv = !bus.i_redirect_valid && (held > 0);
`endif
            check("read_ready", {31'b0, bus.o_read_ready}, 32'd1);
            check("read_valid", {31'b0, bus.o_read_valid}, {31'b0, exp_rv});
            if (exp_rv) check("read_addr", bus.o_read_addr, mpc);
            check("inst_valid", {31'b0, bus.o_inst_valid}, {31'b0, exp_iv});
            if (exp_iv) begin
                if (expq.size() == 0) begin
                    check("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    check("inst_pc", bus.o_inst_pc, expq[0]);
                    check("inst_data", bus.o_inst_data, mem_word(expq[0]));
                end
            end
            if (resp) void'(pend.pop_front());
            if (exp_rv && bus.i_read_ready) begin
                pend.push_back('{mpc, cyc + 1 + ((cyc < 60) ? 0 : int'($urandom_range(0, 3))), ep});
                expq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
            if (bus.i_redirect_valid) begin
                expq.delete();
                held = 0;
                ep++;
                mpc = bus.i_redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (live) held++;
                if (exp_iv && bus.i_inst_ready) begin
                    if (expq.size() > 0) void'(expq.pop_front());
                    held--;
                    consumed++;
                end
            end
        end
    end

    // Stimulus: directed phases first (streaming, stalled decode, fixed redirects), then random.
    initial begin
        bit det;
        rstn                 = 1'b0;
        bus.i_read_ready     = 1'b0;
        bus.i_read_valid     = 1'b0;
        bus.i_read_data      = 32'h0;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = 32'h0;
        bus.i_inst_ready     = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc  = c;
            det  = (c < 60);
            rstn = !(c < 4 || (c >= 300 && c < 303));
            bus.i_read_ready     = det ? 1'b1 : ($urandom_range(0, 9) < 7);
            bus.i_inst_ready     = (c >= 40 && c < 60) ? 1'b0 : (det ? 1'b1 : ($urandom_range(0, 9) < 6));
            bus.i_redirect_valid = 1'b0;
            bus.i_redirect_pc    = $urandom;
            if (c == 60) begin
                bus.i_redirect_valid = 1'b1;
                bus.i_redirect_pc    = 32'h0000_0103;
            end else if (c == 90) begin
                bus.i_redirect_valid = 1'b1;
                bus.i_redirect_pc    = 32'hFFFF_FFFC;
            end else if (c > 100 && $urandom_range(0, 24) == 0) begin
                bus.i_redirect_valid = 1'b1;
                if ($urandom_range(0, 4) == 0) bus.i_redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            end
            bus.i_read_valid = 1'b0;
            bus.i_read_data  = $urandom;
            if (pend.size() > 0) begin
                if (pend[0].rdy <= c && (det || $urandom_range(0, 9) < 7)) begin
                    bus.i_read_valid = 1'b1;
                    bus.i_read_data  = mem_word(pend[0].addr);
                end
            end else if (!det && $urandom_range(0, 19) == 0) begin
                bus.i_read_valid = 1'b1;
            end
        end
        @(posedge clk);
        #2;
        check("progress", {31'b0, consumed > 100}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kv_fetch.md
KV_FETCH -- requirements
Module: kv_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, power of two >= 2: instruction buffer entries and maximum in-flight credit.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rstn  in  1  synchronous reset, active-low.
REQ-005 o_read_addr  out  32  fetch address to memory.
REQ-006 o_read_valid  out  1  fetch request valid.
REQ-007 i_read_ready  in  1  memory accepts the request.
REQ-008 i_read_data  in  32  response instruction word.
REQ-009 i_read_valid  in  1  response valid.
REQ-010 o_read_ready  out  1  fetch accepts the response.
REQ-011 i_redirect_valid  in  1  one-cycle PC redirect (branch/trap).
REQ-012 i_redirect_pc  in  32  redirect target.
REQ-013 o_inst_valid  out  1  instruction available to decode.
REQ-014 o_inst_data  out  32  instruction word.
REQ-015 o_inst_pc  out  32  address of o_inst_data.
REQ-016 i_inst_ready  in  1  decode consumes the instruction.

Function
REQ-017 A request handshake (o_read_valid & i_read_ready) SHALL advance fetch_pc by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 o_read_addr SHALL equal fetch_pc, with bits [1:0] always 2'b00.
REQ-019 o_read_valid SHALL be 1 iff (outstanding + buffer count) < DEPTH and i_redirect_valid = 0.
REQ-020 Once asserted, o_read_valid and o_read_addr SHALL hold until handshake, except in a redirect cycle, where o_read_valid SHALL be 0.
REQ-021 Responses SHALL return in request order; each response SHALL be tagged with the PC of its request via an internal DEPTH-entry PC queue.
REQ-022 o_read_ready SHALL be 1 in every non-reset cycle; the credit rule of REQ-019 guarantees buffer space.
REQ-023 A response with outstanding = 0 SHALL be discarded without any state change.
REQ-024 Buffer: DEPTH-entry FIFO of {pc, data}; o_inst_valid = buffer not empty and i_redirect_valid = 0; the head entry SHALL pop on o_inst_valid & i_inst_ready.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged; a pop from a full buffer frees one credit in the next cycle.
REQ-026 Redirect (i_redirect_valid = 1) SHALL set fetch_pc <= {i_redirect_pc[31:2], 2'b00}, flush the buffer, and set kill_count <= outstanding - (i_read_valid ? 1 : 0).
REQ-027 A response arriving in the redirect cycle SHALL be discarded.
REQ-028 While kill_count > 0, each response SHALL be discarded and SHALL decrement both kill_count and outstanding; it SHALL NOT be written to the buffer.
REQ-029 outstanding SHALL count request handshakes minus responses, and be sized clog2(DEPTH)+1 bits.
REQ-030 Consecutive redirect cycles SHALL each reapply REQ-026; the last target wins.

Reset
REQ-031 While i_rstn = 0 at a clock edge: fetch_pc <= RESET_PC, outstanding <= 0, kill_count <= 0, buffer emptied.
REQ-032 While i_rstn = 0: o_read_valid = 0, o_read_ready = 0, o_inst_valid = 0, o_inst_data = 0, o_inst_pc = 0.
REQ-033 The first request SHALL be presented in the first cycle after i_rstn rises.
REQ-034 Reset asserted mid-operation SHALL abandon all in-flight requests with no kill accounting; responses received during reset are ignored.

Configuration
REQ-035 Macro KV_FETCH_BYPASS_EN defined: when the buffer is empty and a non-killed response arrives, o_inst_valid/o_inst_data/o_inst_pc SHALL present it in the same cycle.
REQ-036 With KV_FETCH_BYPASS_EN, if i_inst_ready = 1 in that cycle, the response SHALL NOT be written to the buffer; otherwise it SHALL be written.
REQ-037 Macro undefined: every response SHALL be written to the buffer and appear on o_inst_* no earlier than the next cycle.

Verification
REQ-038 Reset release, memory always ready, 1-cycle response latency, i_inst_ready = 1 -> requests at 0x0, 0x4, 0x8, ... in consecutive cycles; o_inst_pc follows in order with matching data.
REQ-039 i_inst_ready = 0, memory responsive -> exactly 4 request handshakes, then o_read_valid = 0; buffer holds PCs 0x0-0xC; releasing i_inst_ready resumes fetch at 0x10.
REQ-040 Two requests outstanding, redirect to 32'h0000_0103 -> next request address 0x100; both stale responses are dropped; first o_inst_pc = 0x100.
REQ-041 Redirect in the same cycle as a response and an o_inst handshake -> response dropped, o_inst_valid = 0 that cycle, buffer empty the next cycle.
REQ-042 Redirect to 0xFFFF_FFFC -> fetch addresses 0xFFFF_FFFC, 0x0000_0000.
REQ-043 With KV_FETCH_BYPASS_EN, buffer empty, response 32'h0000_0013 with i_inst_ready = 1 -> o_inst_valid = 1 with that data in the same cycle, buffer count stays 0; without the macro, o_inst_valid = 1 one cycle later.
